// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory controller slice.
package dmem_pkg;

  localparam int MASK_W     = 4;
  localparam int BYTE_W     = 8;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Memory-stage <-> data-memory controller bus. access_err exists only when
// DMEM_OOB_ERR_EN is defined.
interface data_mem_ctrl_if
  import dmem_pkg::*;
#(
  parameter int DataWidth = 32
);

  logic                 request;
  logic                 we_re;
  logic [MASK_W-1:0]    mask;
  logic [DataWidth-1:0] address;
  logic [DataWidth-1:0] store_data;
  logic [DataWidth-1:0] load_data;
  logic                 data_valid;
  logic                 busy;
`ifdef DMEM_OOB_ERR_EN
  logic                 access_err;
`endif

  modport master (
    output request, we_re, mask, address, store_data,
`ifdef DMEM_OOB_ERR_EN
    input  access_err,
`endif
    input  load_data, data_valid, busy
  );

  modport slave (
    input  request, we_re, mask, address, store_data,
`ifdef DMEM_OOB_ERR_EN
    output access_err,
`endif
    output load_data, data_valid, busy
  );

endinterface

// File: rtl/dmem_array.sv
// Depth x DataWidth synchronous RAM: per-byte write enables, registered read
// port with a clear input so out-of-range loads can return zero.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024,
  parameter int IdxW      = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MASK_W-1:0]    wr_be,
  input  logic [IdxW-1:0]      idx,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 rd_en,
  input  logic                 rd_clr,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem [Depth];

  // Contents are never reset; only enabled lanes are touched.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MASK_W; i++) begin
      if (wr_be[i]) begin
        mem[idx][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: latches one access, waits WaitCycles, then performs a
// byte-masked store or word load. DMEM_OOB_ERR_EN adds out-of-range detection.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int Depth      = 1024,
  parameter int WaitCycles = 1
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(Depth);

  dmem_state_e           state_reg;
  logic [WAIT_CNT_W-1:0] cnt_reg;
  logic [DataWidth-1:0]  addr_reg;
  logic [DataWidth-1:0]  wdata_reg;
  logic [MASK_W-1:0]     mask_reg;
  logic                  we_reg;
  logic                  data_valid_reg;

  logic                  accept;
  logic                  enter_resp;
  logic                  acc_we;
  logic [MASK_W-1:0]     acc_mask;
  logic [DataWidth-1:0]  acc_addr;
  logic [DataWidth-1:0]  acc_wdata;
  logic [IDX_W-1:0]      acc_idx;
  logic                  acc_oob;
  logic [MASK_W-1:0]     ram_be;
  logic                  ram_rd_en;
  logic                  ram_rd_clr;
  logic [DataWidth-1:0]  ram_rd_data;
  logic                  unused_addr_bits;

  // With zero wait states the RAM is accessed on the accept edge itself, so the
  // live bus operands bypass the (not yet loaded) operand registers.
  always_comb begin
    accept     = (state_reg == IDLE) && bus.request;
    enter_resp = (WaitCycles == 0) ? accept
                                   : ((state_reg == WAIT) && (cnt_reg == '0));
    if (state_reg == IDLE) begin
      acc_we    = bus.we_re;
      acc_mask  = bus.mask;
      acc_addr  = bus.address;
      acc_wdata = bus.store_data;
    end else begin
      acc_we    = we_reg;
      acc_mask  = mask_reg;
      acc_addr  = addr_reg;
      acc_wdata = wdata_reg;
    end
    acc_idx = acc_addr[IDX_W+1:2];
`ifdef DMEM_OOB_ERR_EN
    acc_oob = (acc_addr >= DataWidth'(Depth * 4));
`else
    acc_oob = 1'b0;
`endif
    ram_be     = (enter_resp && acc_we && !acc_oob && !rst) ? acc_mask : '0;
    ram_rd_en  = enter_resp && !acc_we && !rst;
    ram_rd_clr = ram_rd_en && acc_oob;
  end

  assign unused_addr_bits = ^{acc_addr[DataWidth-1:IDX_W+2], acc_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      mask_reg       <= '0;
      we_reg         <= 1'b0;
      data_valid_reg <= 1'b0;
    end else begin
      data_valid_reg <= enter_resp;
      case (state_reg)
        IDLE: begin
          if (bus.request) begin
            addr_reg  <= bus.address;
            wdata_reg <= bus.store_data;
            mask_reg  <= bus.mask;
            we_reg    <= bus.we_re;
            if (WaitCycles == 0) begin
              state_reg <= RESP;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= WAIT_CNT_W'(WaitCycles - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef DMEM_OOB_ERR_EN
  logic access_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      access_err_reg <= 1'b0;
    end else begin
      access_err_reg <= enter_resp && acc_oob;
    end
  end

  assign bus.access_err = access_err_reg;
`endif

  dmem_array #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .IdxW      (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_be   (ram_be),
    .idx     (acc_idx),
    .wr_data (acc_wdata),
    .rd_en   (ram_rd_en),
    .rd_clr  (ram_rd_clr),
    .rd_data (ram_rd_data)
  );

  assign bus.load_data  = ram_rd_data;
  assign bus.data_valid = data_valid_reg;
  assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: one controller with one wait state, one with none.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic last_err = 1'b0;

  data_mem_ctrl_if #(.DataWidth(32)) bus1 ();
  data_mem_ctrl_if #(.DataWidth(32)) bus0 ();

  data_mem_ctrl #(.DataWidth(32), .Depth(1024), .WaitCycles(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  data_mem_ctrl #(.DataWidth(32), .Depth(1024), .WaitCycles(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One access on the WaitCycles=1 controller; lat counts negedges after accept.
  task automatic access(input logic we, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output int lat, output int busy_n);
    @(posedge clk); #1;
    bus1.request = 1'b1; bus1.we_re = we; bus1.mask = m;
    bus1.address = a;    bus1.store_data = d;
    @(posedge clk); #1;
    bus1.request = 1'b0;
    lat = 0; busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (bus1.busy) busy_n++;
      if (bus1.data_valid) break;
    end
    if (!bus1.data_valid) lat = 99;
    rd = bus1.load_data;
`ifdef DMEM_OOB_ERR_EN
    last_err = bus1.access_err;
`endif
  endtask

  task automatic st(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d,
                    input string tag, output logic [31:0] rd);
    int lat, bn;
    access(1'b1, m, a, d, rd, lat, bn);
    check({tag, "_lat"}, lat, 2);
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    int lat, bn;
    access(1'b0, 4'h0, a, 32'h0, rd, lat, bn);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_data"}, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    int lat, bn, dv_n;

    bus1.request = 0; bus1.we_re = 0; bus1.mask = 0; bus1.address = 0; bus1.store_data = 0;
    bus0.request = 0; bus0.we_re = 0; bus0.mask = 0; bus0.address = 0; bus0.store_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_dv", bus1.data_valid, 0);
    check("reset_load_data", bus1.load_data, 0);
    check("reset_busy", bus1.busy, 0);
    check("reset_dv_w0", bus0.data_valid, 0);

    // Preload then load with busy/latency observation (mask ignored on load)
    st(4'hF, 32'h10, 32'hDEADBEEF, "st10", rd);
    access(1'b0, 4'h0, 32'h10, 32'h0, rd, lat, bn);
    check("ld10_lat", lat, 2);
    check("ld10_busy_cycles", bn, 2);
    check("ld10_data", rd, 32'hDEADBEEF);
    @(negedge clk);
    check("ld10_dv_one_cycle", bus1.data_valid, 0);
    check("ld10_busy_after", bus1.busy, 0);

    // Byte-masked store; load_data holds across stores
    st(4'hF, 32'h20, 32'h11111111, "st20_fill", rd);
    st(4'b0101, 32'h20, 32'hAABBCCDD, "st20_mask", rd);
    check("st_holds_load_data", rd, 32'hDEADBEEF);
    ld(32'h20, 32'h11BB11DD, "ld20");
    ld(32'h22, 32'h11BB11DD, "ld22_low_bits_ignored");

    // Mask zero store still responds but leaves the word intact
    st(4'hF, 32'h30, 32'h12345678, "st30", rd);
    st(4'h0, 32'h30, 32'hFFFFFFFF, "st30_mask0", rd);
    ld(32'h30, 32'h12345678, "ld30");

    // Request and operands changing during WAIT/RESP are ignored
    @(posedge clk); #1;
    bus1.request = 1'b1; bus1.we_re = 1'b0; bus1.address = 32'h10;
    @(posedge clk); #1;
    bus1.we_re = 1'b1; bus1.mask = 4'hF; bus1.address = 32'h30; bus1.store_data = 32'h0;
    @(negedge clk);
    check("hold_wait_busy", bus1.busy, 1);
    check("hold_wait_dv", bus1.data_valid, 0);
    @(negedge clk);
    check("hold_resp_dv", bus1.data_valid, 1);
    check("hold_resp_data", bus1.load_data, 32'hDEADBEEF);
    bus1.request = 1'b0;
    @(negedge clk);
    check("hold_idle_busy", bus1.busy, 0);
    ld(32'h30, 32'h12345678, "ld30_untouched");

    // Reset during WAIT aborts the store
    st(4'hF, 32'h40, 32'h0, "st40_zero", rd);
    @(posedge clk); #1;
    bus1.request = 1'b1; bus1.we_re = 1'b1; bus1.mask = 4'hF;
    bus1.address = 32'h40; bus1.store_data = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus1.request = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("abort_busy_in_wait", bus1.busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", bus1.busy, 0);
    check("abort_load_data", bus1.load_data, 0);
    dv_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus1.data_valid) dv_n++;
    end
    check("abort_no_dv", dv_n, 0);
    ld(32'h40, 32'h0, "ld40");

    // Aliasing versus out-of-range handling
    st(4'hF, 32'h4, 32'hCAFEF00D, "st4", rd);
    access(1'b0, 4'hF, 32'h1004, 32'h0, rd, lat, bn);
    check("ld1004_lat", lat, 2);
`ifdef DMEM_OOB_ERR_EN
    check("ld1004_data", rd, 32'h0);
    check("ld1004_err", last_err, 1);
    access(1'b0, 4'hF, 32'h4, 32'h0, rd, lat, bn);
    check("ld4_err", last_err, 0);
    st(4'hF, 32'h1004, 32'h0, "st1004", rd);
    ld(32'h4, 32'hCAFEF00D, "ld4_no_oob_write");
`else
    check("ld1004_data", rd, 32'hCAFEF00D);
    st(4'hF, 32'h1004, 32'h0, "st1004", rd);
    ld(32'h4, 32'h0, "ld4_aliased_write");
`endif

    // WaitCycles=0: request held high gives one response every two cycles
    @(posedge clk); #1;
    bus0.request = 1'b1; bus0.we_re = 1'b1; bus0.mask = 4'hF;
    bus0.address = 32'h8; bus0.store_data = 32'h55;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("b2b_dv_%0d", i), bus0.data_valid, (i % 2 == 0) ? 1 : 0);
      check($sformatf("b2b_busy_%0d", i), bus0.busy, (i % 2 == 0) ? 1 : 0);
    end
    bus0.request = 1'b0;
    @(posedge clk); #1;
    bus0.request = 1'b1; bus0.we_re = 1'b0; bus0.address = 32'h8;
    @(posedge clk); #1;
    bus0.request = 1'b0;
    @(negedge clk);
    check("w0_ld_dv", bus0.data_valid, 1);
    check("w0_ld_data", bus0.load_data, 32'h55);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory controller directly downstream of the memory stage. Consumes request/we_re/mask/address/store data, performs a byte-masked write or a word read on an internal synchronous RAM after a programmable number of wait states, and returns a one-cycle data_valid with load data. The memory stage's load wrapper consumes load_data/data_valid. busy stalls the pipeline while an access is in flight.

Parameters:
DataWidth, 32, data/address bus width
Depth, 1024, RAM depth in words (power of two)
WaitCycles, 1, extra wait states before response (0..15)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
request  input  1  access request from memory stage
we_re  input  1  1 = store, 0 = load (sampled with request)
mask  input  4  byte-lane enables, bit i -> bits [8i+7:8i]
address  input  DataWidth  byte address (ALU result)
store_data  input  DataWidth  lane-aligned store data
load_data  output  DataWidth  full word read from RAM
data_valid  output  1  one-cycle response pulse
busy  output  1  access in flight; upstream holds request/operands

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high on rst. Reset: state IDLE, data_valid=0, load_data=0, wait counter=0. RAM contents not reset.
- States: IDLE, WAIT, RESP (enum in package).
- IDLE: request=1 at edge E -> latch address, we_re, mask, store_data. Go to WAIT with counter=WaitCycles-1 if WaitCycles>0, else RESP.
- WAIT: decrement counter each edge; at counter==0 go to RESP.
- Entering RESP, on the same edge: store -> write lanes with mask[i]=1, others untouched; load -> load_data <= RAM[index]; data_valid <= 1.
- RESP lasts exactly one cycle with data_valid=1, then IDLE, data_valid <= 0. A request present in RESP is not accepted; accepted at the following IDLE edge.
- Latency: data_valid high in cycle E+WaitCycles+1. Throughput: one access per WaitCycles+2 cycles.
- busy = (state != IDLE), combinational from state.
- Word index = address[log2(Depth)+1:2]. address[1:0] ignored; lanes come from mask. Upper bits ignored, so addresses alias modulo Depth*4.
- Store with mask=4'b0000: no RAM change, data_valid still pulses.
- Store: load_data holds its previous value.
- Load: mask ignored, full word returned.
- request in WAIT/RESP: ignored; latched operands do not change.
- rst mid-access: returns to IDLE next edge. No write occurs unless the RESP-entry edge has already passed. No data_valid is issued for the aborted access.

Optional Feature:
DMEM_OOB_ERR_EN. Defined: adds output access_err (1 bit, reset 0). If latched address >= Depth*4, the access performs no write and returns load_data=0. access_err pulses together with data_valid. Not defined: no port, aliasing as above.

Decomposition:
- Package dmem_pkg: state enum dmem_state_e {IDLE, WAIT, RESP}, MASK_W=4, BYTE_W=8, WAIT_CNT_W=4.
- Sub-module dmem_array: Depth x DataWidth synchronous RAM with per-byte write enable and a registered read port. Controller FSM stays in data_mem_ctrl.

Test Plan:
- WaitCycles=1, load of preloaded 0xDEADBEEF at 0x10 -> busy high 2 cycles, data_valid pulse in cycle E+2, load_data=0xDEADBEEF.
- Store 0xAABBCCDD, mask 4'b0101, at 0x20 over 0x11111111, then load 0x20 -> load_data=0x11BB11DD.
- WaitCycles=0, back-to-back requests held high -> data_valid every 2 cycles; second access accepted only after the RESP cycle.
- Store with mask 0 to 0x30 holding 0x12345678 -> data_valid pulses, reload returns 0x12345678.
- rst asserted in WAIT during store of 0xFFFFFFFF to 0x40 (holding 0) -> no data_valid, busy=0 next cycle, reload returns 0.
- Depth=1024, load 0x1004 after store 0xCAFEF00D to 0x4 -> aliased read 0xCAFEF00D. With DMEM_OOB_ERR_EN: access_err=1, load_data=0.
